// File: rtl/lpf_pkg.sv
// Shared types and helpers for the IMU moving-average low-pass filter.
package lpf_pkg;

    typedef enum logic [2:0] {IDLE, RD, UPD, DIV, WR, PUB} state_t;
    typedef enum logic [1:0] {AX_X, AX_Y, AX_Z} axis_t;

    // Smallest width that holds a full window of maximum-valued samples.
    function automatic int sum_width(input int len, input int dw);
        return $clog2(len * ((1 << dw) - 1) + 1);
    endfunction

endpackage

// File: rtl/lpf_seq_divider.sv
// Unsigned restoring divider by a constant; one quotient bit per cycle,
// done is high in the SUM_W-th cycle after the start cycle.
module lpf_seq_divider #(
    parameter int SUM_W   = 17,
    parameter int DIVISOR = 67,
    parameter int Q_W     = 10
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             start,
    input  logic [SUM_W-1:0] dividend,
    output logic             done,
    output logic [Q_W-1:0]   quotient
);

    localparam int CNT_W = $clog2(SUM_W + 1);
    localparam logic [SUM_W:0] DIV_V = (SUM_W + 1)'(DIVISOR);

    logic [SUM_W-1:0] rem_q, rem_d, quo_q, quo_d;
    logic [SUM_W-1:0] src_rem, src_quo;
    logic [SUM_W:0]   trial;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             ge, step;

    assign done     = busy_q && (cnt_q == CNT_W'(SUM_W));
    assign quotient = quo_q[Q_W-1:0];

    // The start cycle already retires the first bit, so the last bit lands
    // in the register just as done is raised.
    always_comb begin
        src_rem = start ? '0 : rem_q;
        src_quo = start ? dividend : quo_q;
        trial   = {src_rem, src_quo[SUM_W-1]};
        ge      = (trial >= DIV_V);
        step    = start || (busy_q && !done);
        rem_d   = rem_q;
        quo_d   = quo_q;
        cnt_d   = cnt_q;
        busy_d  = busy_q;
        if (step) begin
            rem_d  = ge ? (trial[SUM_W-1:0] - DIV_V[SUM_W-1:0]) : trial[SUM_W-1:0];
            quo_d  = {src_quo[SUM_W-2:0], ge};
            cnt_d  = start ? CNT_W'(1) : cnt_q + CNT_W'(1);
            busy_d = 1'b1;
        end else if (done) begin
            busy_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            rem_q  <= '0;
            quo_q  <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
        end else begin
            rem_q  <= rem_d;
            quo_q  <= quo_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/lpf_avg_sequencer.sv
// Moving-average low-pass filter for 3-axis accel samples: running sums per
// axis, one shared sequential divider, one filtered triple per accepted sample.
module lpf_avg_sequencer
    import lpf_pkg::*;
#(
    parameter int FILTER_LEN = 67,
    parameter int DATA_W     = 10
) (
    input  logic              Clock,
    input  logic              nReset,
    input  logic              SampleValid,
    output logic              SampleReady,
    input  logic [DATA_W-1:0] AccelX,
    input  logic [DATA_W-1:0] AccelY,
    input  logic [DATA_W-1:0] AccelZ,
    input  logic              ClearOverrun,
    output logic [DATA_W-1:0] AccelXOut,
    output logic [DATA_W-1:0] AccelYOut,
    output logic [DATA_W-1:0] AccelZOut,
    output logic              OutValid,
    output logic              Primed,
    output logic              Overrun
);

    localparam int SUM_W  = sum_width(FILTER_LEN, DATA_W);
    localparam int PTR_W  = $clog2(FILTER_LEN);
    localparam int CNT_W  = $clog2(FILTER_LEN + 1);
    localparam int WORD_W = 3 * DATA_W;

    state_t            state_q, state_d;
    axis_t             axis_q, axis_d;
    logic [WORD_W-1:0] sample_q, sample_d;
    logic [WORD_W-1:0] old_word_q;
    logic [WORD_W-1:0] mem [FILTER_LEN];
    logic [SUM_W-1:0]  sum_q [3];
    logic [SUM_W-1:0]  sum_d [3];
    logic [DATA_W-1:0] res_q [3];
    logic [DATA_W-1:0] res_d [3];
    logic [DATA_W-1:0] out_q [3];
    logic [DATA_W-1:0] out_d [3];
    logic              out_valid_q, out_valid_d;
    logic              primed_q, primed_d;
    logic              overrun_q, overrun_d;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [DATA_W-1:0] new_val, old_val;
    logic [SUM_W-1:0]  upd_sum;
    logic              div_start, div_done;
    logic [DATA_W-1:0] div_quo;

    assign SampleReady = (state_q == IDLE);
    assign AccelXOut   = out_q[AX_X];
    assign AccelYOut   = out_q[AX_Y];
    assign AccelZOut   = out_q[AX_Z];
    assign OutValid    = out_valid_q;
    assign Primed      = primed_q;
    assign Overrun     = overrun_q;
    assign div_start   = (state_q == UPD);

    // Until the window has filled, the RAM slot being replaced holds stale data.
    always_comb begin
        new_val = sample_q[int'(axis_q) * DATA_W +: DATA_W];
        old_val = (count_q == CNT_W'(FILTER_LEN)) ? old_word_q[int'(axis_q) * DATA_W +: DATA_W] : '0;
        upd_sum = sum_q[axis_q] + SUM_W'(new_val) - SUM_W'(old_val);
    end

    lpf_seq_divider #(
        .SUM_W   (SUM_W),
        .DIVISOR (FILTER_LEN),
        .Q_W     (DATA_W)
    ) u_div (
        .Clock    (Clock),
        .nReset   (nReset),
        .start    (div_start),
        .dividend (upd_sum),
        .done     (div_done),
        .quotient (div_quo)
    );

    always_ff @(posedge Clock) begin
        if (state_q == WR) mem[wr_ptr_q] <= sample_q;
        if (state_q == RD) old_word_q <= mem[wr_ptr_q];
    end

    always_comb begin
        state_d     = state_q;
        axis_d      = axis_q;
        sample_d    = sample_q;
        sum_d       = sum_q;
        res_d       = res_q;
        out_d       = out_q;
        out_valid_d = 1'b0;
        primed_d    = primed_q;
        overrun_d   = overrun_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;

        if (ClearOverrun) overrun_d = 1'b0;
        if (SampleValid && state_q != IDLE) overrun_d = 1'b1;

        case (state_q)
            IDLE: begin
                if (SampleValid) begin
                    sample_d = {AccelZ, AccelY, AccelX};
                    axis_d   = AX_X;
                    state_d  = RD;
                end
            end
            RD:  state_d = UPD;
            UPD: begin
                sum_d[axis_q] = upd_sum;
                state_d       = DIV;
            end
            DIV: begin
                if (div_done) begin
                    res_d[axis_q] = div_quo;
                    if (axis_q == AX_Z) begin
                        state_d = WR;
                    end else begin
                        axis_d  = axis_t'(axis_q + 2'd1);
                        state_d = UPD;
                    end
                end
            end
            WR: begin
                wr_ptr_d = (wr_ptr_q == PTR_W'(FILTER_LEN - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
                if (count_q != CNT_W'(FILTER_LEN)) count_d = count_q + CNT_W'(1);
                if (count_d == CNT_W'(FILTER_LEN)) primed_d = 1'b1;
                state_d = PUB;
            end
            PUB: begin
                out_d       = res_q;
                out_valid_d = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q     <= IDLE;
            axis_q      <= AX_X;
            sample_q    <= '0;
            out_valid_q <= 1'b0;
            primed_q    <= 1'b0;
            overrun_q   <= 1'b0;
            wr_ptr_q    <= '0;
            count_q     <= '0;
            for (int i = 0; i < 3; i++) begin
                sum_q[i] <= '0;
                res_q[i] <= '0;
                out_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            axis_q      <= axis_d;
            sample_q    <= sample_d;
            out_valid_q <= out_valid_d;
            primed_q    <= primed_d;
            overrun_q   <= overrun_d;
            wr_ptr_q    <= wr_ptr_d;
            count_q     <= count_d;
            sum_q       <= sum_d;
            res_q       <= res_d;
            out_q       <= out_d;
        end
    end

endmodule
